// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/freeze sequencer with halt-drain FSM and stall counter
module pipeline_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_halt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t          state, state_next;
    logic [DC_W-1:0] cnt, cnt_next;
    logic            freeze, load_use, count_stall;

    assign freeze   = mem_access & ~dmem_ready;
    assign load_use = ex_memread & (ex_rd != '0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        count_stall = 1'b0;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_write  = 1'b0;
        idex_flush  = 1'b0;
        exmem_write = 1'b0;
        if (reset) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (state)
                S_RUN: begin
                    if (freeze) begin
                        count_stall = 1'b1;
                    end else if (ex_redirect) begin
                        // wrong-path ID instr: any load_use or halt it carries is squashed
                        pc_write    = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        idex_write  = 1'b1;
                        exmem_write = 1'b1;
                    end else if (load_use) begin
                        idex_flush  = 1'b1;
                        exmem_write = 1'b1;
                        count_stall = 1'b1;
                    end else if (id_halt) begin
                        ifid_write  = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_write  = 1'b1;
                        exmem_write = 1'b1;
                        state_next  = S_DRAIN;
                        cnt_next    = DRAIN_LOAD;
                    end else begin
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        idex_write  = 1'b1;
                        exmem_write = 1'b1;
                    end
                end
                S_DRAIN: begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    idex_write  = ~freeze;
                    exmem_write = ~freeze;
                    if (freeze) begin
                        count_stall = 1'b1;
                    end else if (cnt == '0) begin
                        state_next = S_HALTED;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                S_HALTED: begin
                end
                default: begin
                    state_next = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_RUN;
            cnt          <= '0;
            halted       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            halted <= (state_next == S_HALTED);
            if (count_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule
